// File: rtl/meta_package.sv
// -----------------------------------------------------------------------------
// meta_package
// Shared metadata types for the packet pipeline. ext_pkt_desc_type is the
// extended packet descriptor handed from the parser/classifier to the
// scheduler/editor.
// -----------------------------------------------------------------------------
package meta_package;

   typedef struct packed {
      logic [31:0] buf_addr;   // packet buffer base address
      logic [13:0] pkt_len;    // packet length in bytes
      logic [9:0]  flow_id;    // classifier flow index
      logic [2:0]  tc;         // traffic class
      logic        eop_err;    // packet ended with an error
   } ext_pkt_desc_type;

   localparam int EXT_PKT_DESC_NBITS = $bits(ext_pkt_desc_type);

endpackage

// File: rtl/ram_1r1w_bram_ext_pkt_desc.sv
// -----------------------------------------------------------------------------
// ram_1r1w_bram_ext_pkt_desc
// Simple dual-port descriptor RAM, one write port and one read port, with a
// registered read (dout reflects raddr from the previous cycle). Contents are
// never reset so the array maps onto block RAM.
//
// Ports:
//   clk    in   clock
//   wr     in   write enable
//   waddr  in   write address
//   din    in   write data
//   raddr  in   read address (sampled every cycle)
//   dout   out  read data, one cycle after raddr
// -----------------------------------------------------------------------------
module ram_1r1w_bram_ext_pkt_desc
   import meta_package::*;
#(
   parameter int DEPTH_NBITS = 4
) (
   input  logic                   clk,
   input  logic                   wr,
   input  logic [DEPTH_NBITS-1:0] waddr,
   input  ext_pkt_desc_type       din,
   input  logic [DEPTH_NBITS-1:0] raddr,
   output ext_pkt_desc_type       dout
);

   localparam int DEPTH = 1 << DEPTH_NBITS;

   ext_pkt_desc_type mem [DEPTH];
   ext_pkt_desc_type dout_q;

   always_ff @(posedge clk) begin
      if (wr) begin
         mem[waddr] <= din;
      end
      dout_q <= mem[raddr];
   end

   assign dout = dout_q;

endmodule

// File: rtl/ext_pkt_desc_queue.sv
// -----------------------------------------------------------------------------
// ext_pkt_desc_queue
// Show-ahead FIFO for extended packet descriptors. Pointers and occupancy
// sequence one registered-read RAM; a 2-entry skid in front of the dequeue
// port hides the RAM read latency so the consumer sees the head descriptor
// directly and can take one per cycle.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous discard of all contents (clears overflow too)
//   enq_valid  in   write request, accepted when full=0
//   enq_desc   in   descriptor to write
//   full       out  registered, count==DEPTH
//   deq_valid  out  registered, deq_desc holds the queue head
//   deq_desc   out  head descriptor (skid slot 0)
//   deq_ready  in   consumer takes the head when deq_valid=1
//   count      out  total occupancy: RAM + in-flight read + skid
//   overflow   out  sticky, enqueue attempted while full
// -----------------------------------------------------------------------------
module ext_pkt_desc_queue
   import meta_package::*;
#(
   parameter int DEPTH_NBITS = 4,
   parameter int DEPTH       = 1 << DEPTH_NBITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 enq_valid,
   input  ext_pkt_desc_type     enq_desc,
   output logic                 full,
   output logic                 deq_valid,
   output ext_pkt_desc_type     deq_desc,
   input  logic                 deq_ready,
   output logic [DEPTH_NBITS:0] count,
   output logic                 overflow
);

   localparam int CNT_NBITS = DEPTH_NBITS + 1;

   logic [DEPTH_NBITS-1:0] wptr_q, wptr_d;
   logic [DEPTH_NBITS-1:0] rptr_q, rptr_d;
   logic [CNT_NBITS-1:0]   ram_cnt_q, ram_cnt_d;
   logic [CNT_NBITS-1:0]   count_q, count_d;
   logic                   full_q, full_d;
   logic                   overflow_q, overflow_d;
   logic                   inflight_q, inflight_d;
   logic                   deq_valid_q, deq_valid_d;
   logic [1:0]             skid_cnt_q, skid_cnt_d;
   ext_pkt_desc_type       slot0_q, slot0_d;
   ext_pkt_desc_type       slot1_q, slot1_d;

   logic                   enq_fire;
   logic                   deq_fire;
   logic                   fetch;
   logic                   ram_wr;
   logic [2:0]             occ_after;
   logic [1:0]             skid_base;
   ext_pkt_desc_type       ram_dout;

   ram_1r1w_bram_ext_pkt_desc #(
      .DEPTH_NBITS (DEPTH_NBITS)
   ) u_ram (
      .clk   (clk),
      .wr    (ram_wr),
      .waddr (wptr_q),
      .din   (enq_desc),
      .raddr (rptr_q),
      .dout  (ram_dout)
   );

   always_comb begin
      enq_fire = enq_valid & ~full_q;
      deq_fire = deq_valid_q & deq_ready;
      ram_wr   = enq_fire & ~flush;

      // Skid slots that will be committed after this edge (held entries plus
      // the landing read, minus the one leaving). Crediting the departing
      // entry lets a fetch issue in the same cycle as a dequeue, which is
      // what keeps a streaming consumer bubble-free.
      occ_after = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(deq_fire);
      fetch     = (ram_cnt_q != '0) && (occ_after < 3'd2);

      wptr_d     = wptr_q + DEPTH_NBITS'(enq_fire);
      rptr_d     = rptr_q + DEPTH_NBITS'(fetch);
      ram_cnt_d  = ram_cnt_q + CNT_NBITS'(enq_fire) - CNT_NBITS'(fetch);
      count_d    = count_q + CNT_NBITS'(enq_fire) - CNT_NBITS'(deq_fire);
      full_d     = (count_d == CNT_NBITS'(DEPTH));
      overflow_d = overflow_q | (enq_valid & full_q);
      inflight_d = fetch;

      // Dequeue shifts slot 1 forward; the landing read then fills the first
      // free slot, so arrival order is preserved.
      skid_base = skid_cnt_q - 2'(deq_fire);
      slot0_d   = deq_fire ? slot1_q : slot0_q;
      slot1_d   = slot1_q;
      if (inflight_q) begin
         if (skid_base == 2'd0) begin
            slot0_d = ram_dout;
         end else begin
            slot1_d = ram_dout;
         end
      end
      skid_cnt_d = skid_base + 2'(inflight_q);

      // Flush wins over everything; the landing read is dropped and the RAM
      // contents are simply abandoned.
      if (flush) begin
         wptr_d     = '0;
         rptr_d     = '0;
         ram_cnt_d  = '0;
         count_d    = '0;
         full_d     = 1'b0;
         overflow_d = 1'b0;
         inflight_d = 1'b0;
         skid_cnt_d = 2'd0;
      end

      deq_valid_d = (skid_cnt_d != 2'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         ram_cnt_q   <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         overflow_q  <= 1'b0;
         inflight_q  <= 1'b0;
         deq_valid_q <= 1'b0;
         skid_cnt_q  <= 2'd0;
         slot0_q     <= '0;
         slot1_q     <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         ram_cnt_q   <= ram_cnt_d;
         count_q     <= count_d;
         full_q      <= full_d;
         overflow_q  <= overflow_d;
         inflight_q  <= inflight_d;
         deq_valid_q <= deq_valid_d;
         skid_cnt_q  <= skid_cnt_d;
         slot0_q     <= slot0_d;
         slot1_q     <= slot1_d;
      end
   end

   assign full      = full_q;
   assign deq_valid = deq_valid_q;
   assign deq_desc  = slot0_q;
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_ext_pkt_desc_queue.sv
// -----------------------------------------------------------------------------
// tb_ext_pkt_desc_queue
// Directed bench for ext_pkt_desc_queue (DEPTH_NBITS=4). Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_ext_pkt_desc_queue;
   import meta_package::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             enq_valid;
   ext_pkt_desc_type enq_desc;
   logic             full;
   logic             deq_valid;
   ext_pkt_desc_type deq_desc;
   logic             deq_ready;
   logic [4:0]       count;
   logic             overflow;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   int               exp_q [$];
   int               next_wr = 0;
   int               max_cnt = 0;
   bit               stall_q = 1'b0;
   ext_pkt_desc_type hold_desc;

   ext_pkt_desc_queue #(.DEPTH_NBITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .enq_valid (enq_valid),
      .enq_desc  (enq_desc),
      .full      (full),
      .deq_valid (deq_valid),
      .deq_desc  (deq_desc),
      .deq_ready (deq_ready),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, observed running expected finished");
      $fatal(1, "time limit");
   end

   function automatic ext_pkt_desc_type mk(input int i);
      ext_pkt_desc_type d;
      d.buf_addr = 32'hA000_0000 + 32'(i) * 32'd64;
      d.pkt_len  = 14'(100 + i);
      d.flow_id  = 10'(i * 3 + 1);
      d.tc       = 3'(i);
      d.eop_err  = ((i % 5) == 0);
      return d;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One cycle of scoreboarded traffic: check state, record what the next
   // edge will do, drive inputs, advance to the next falling edge.
   task automatic drive(input bit ev, input bit rdy);
      bit acc;
      check("sb_count", 64'(count), 64'(exp_q.size()));
      check("sb_full", 64'(full), 64'(exp_q.size() == 16));
      if (exp_q.size() > max_cnt) max_cnt = exp_q.size();
      if (stall_q) check("stall_hold", 64'(deq_desc), 64'(hold_desc));
      acc = ev && (exp_q.size() < 16);
      if (deq_valid && rdy) begin
         if (exp_q.size() == 0) check("deq_spurious", 64'(deq_valid), 64'd0);
         else check("deq_order", 64'(deq_desc), 64'(mk(exp_q.pop_front())));
      end
      stall_q   = deq_valid && !rdy;
      hold_desc = deq_desc;
      enq_valid = ev;
      enq_desc  = mk(next_wr);
      deq_ready = rdy;
      if (acc) begin
         exp_q.push_back(next_wr);
         next_wr++;
      end
      @(negedge clk);
   endtask

   // Enqueue D9 into an empty queue and check the 3-cycle show-ahead latency.
   task automatic latency_d9(input string tag);
      enq_valid = 1'b1; enq_desc = mk(9); deq_ready = 1'b0;
      @(negedge clk);
      enq_valid = 1'b0;
      check({tag, "_cnt1"}, 64'(count), 64'd1);
      check({tag, "_dv1"}, 64'(deq_valid), 64'd0);
      @(negedge clk);
      check({tag, "_dv2"}, 64'(deq_valid), 64'd0);
      @(negedge clk);
      check({tag, "_dv3"}, 64'(deq_valid), 64'd1);
      check({tag, "_desc"}, 64'(deq_desc), 64'(mk(9)));
      deq_ready = 1'b1;
      @(negedge clk);
      deq_ready = 1'b0;
      check({tag, "_dv4"}, 64'(deq_valid), 64'd0);
      check({tag, "_cnt4"}, 64'(count), 64'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_desc = '0; deq_ready = 1'b0;
      @(negedge clk);
      check("rst_full", 64'(full), 64'd0);
      check("rst_dv", 64'(deq_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single enqueue: visible three cycles later, gone one cycle after.
      enq_valid = 1'b1; enq_desc = mk(0); deq_ready = 1'b1;
      @(negedge clk);
      enq_valid = 1'b0;
      check("single_cnt1", 64'(count), 64'd1);
      check("single_dv1", 64'(deq_valid), 64'd0);
      @(negedge clk);
      check("single_dv2", 64'(deq_valid), 64'd0);
      @(negedge clk);
      check("single_dv3", 64'(deq_valid), 64'd1);
      check("single_desc", 64'(deq_desc), 64'(mk(0)));
      check("single_cnt3", 64'(count), 64'd1);
      @(negedge clk);
      check("single_dv4", 64'(deq_valid), 64'd0);
      check("single_cnt4", 64'(count), 64'd0);

      // Fill to full with the consumer stalled.
      deq_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            check("fill_cnt15", 64'(count), 64'd15);
            check("fill_full15", 64'(full), 64'd0);
         end
         enq_valid = 1'b1; enq_desc = mk(i);
         @(negedge clk);
      end
      enq_valid = 1'b0;
      check("fill_cnt16", 64'(count), 64'd16);
      check("fill_full16", 64'(full), 64'd1);
      check("fill_ovf0", 64'(overflow), 64'd0);
      enq_valid = 1'b1; enq_desc = mk(99);
      @(negedge clk);
      enq_valid = 1'b0;
      check("ovf_set", 64'(overflow), 64'd1);
      check("ovf_cnt", 64'(count), 64'd16);
      check("ovf_full", 64'(full), 64'd1);

      // Enqueue + dequeue together while full: enqueue rejected.
      check("simul_dv", 64'(deq_valid), 64'd1);
      check("simul_head", 64'(deq_desc), 64'(mk(0)));
      enq_valid = 1'b1; enq_desc = mk(98); deq_ready = 1'b1;
      @(negedge clk);
      enq_valid = 1'b0;
      check("simul_cnt", 64'(count), 64'd15);
      check("simul_full", 64'(full), 64'd0);
      check("simul_ovf", 64'(overflow), 64'd1);

      // Drain with ready held: one per cycle, in order, no bubbles.
      for (int i = 1; i < 16; i++) begin
         check("drain_dv", 64'(deq_valid), 64'd1);
         check("drain_desc", 64'(deq_desc), 64'(mk(i)));
         @(negedge clk);
      end
      deq_ready = 1'b0;
      check("drain_cnt", 64'(count), 64'd0);
      check("drain_dv_end", 64'(deq_valid), 64'd0);

      // Consumer stall mid-stream, scoreboarded.
      next_wr = 20;
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
      for (int i = 0; i < 14; i++) drive(1'b0, 1'b1);
      check("stall_empty", 64'(exp_q.size()), 64'd0);
      check("stall_cnt", 64'(count), 64'd0);

      // Flush at count=7 with a read in flight.
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      check("pre_flush_cnt", 64'(count), 64'd7);
      flush = 1'b1; enq_valid = 1'b1; enq_desc = mk(77); deq_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
      exp_q.delete();
      stall_q = 1'b0;
      check("flush_cnt", 64'(count), 64'd0);
      check("flush_dv", 64'(deq_valid), 64'd0);
      check("flush_ovf", 64'(overflow), 64'd0);
      check("flush_full", 64'(full), 64'd0);
      latency_d9("flush_d9");

      // Pointer wrap: 40 descriptors, 50% enqueue/dequeue.
      next_wr = 200;
      max_cnt = 0;
      for (int c = 0; c < 600 && next_wr < 240; c++)
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("wrap_pushed", 64'(next_wr), 64'd240);
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      check("wrap_empty", 64'(exp_q.size()), 64'd0);
      check("wrap_max", 64'(max_cnt <= 16), 64'd1);
      check("wrap_ovf", 64'(overflow), 64'd0);

      // Async reset mid-stream.
      next_wr = 300;
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
      rst = 1'b1;
      #1;
      check("arst_dv", 64'(deq_valid), 64'd0);
      check("arst_cnt", 64'(count), 64'd0);
      check("arst_full", 64'(full), 64'd0);
      check("arst_ovf", 64'(overflow), 64'd0);
      enq_valid = 1'b0; deq_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      stall_q = 1'b0;
      @(negedge clk);
      check("arst_dv_idle", 64'(deq_valid), 64'd0);
      latency_d9("arst_d9");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
